// File: rtl/ddr3_pkg.sv
// Shared definitions for the DDR3 controller and its client-side requesters:
// client command codes, requester state encoding and address helpers.
package ddr3_pkg;

  localparam int unsigned ADDR_W = 26;
  localparam int unsigned DATA_W = 16;

  // Client-port command codes understood by the controller
  typedef enum logic [2:0] {
    CMD_NOP = 3'b000,
    CMD_SCR = 3'b001,
    CMD_SCW = 3'b010
  } cmd_t;

  // Host requester sequencing states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_ISSUE = 2'd1,
    ST_RD_RUN   = 2'd2,
    ST_DONE     = 2'd3
  } req_state_t;

  // Next word address; the controller address space wraps at 2^ADDR_W
  function automatic logic [ADDR_W-1:0] addr_next(input logic [ADDR_W-1:0] a);
    return a + 26'd1;
  endfunction

endpackage

// File: rtl/ddr3_host_requester.sv
// Host-side initiator for the DDR3 controller client port. Breaks one block
// request into single-word SCW/SCR commands, throttles reads to MAX_OUT
// outstanding, pops the show-ahead return FIFO and checks return addresses.
module ddr3_host_requester
  import ddr3_pkg::*;
#(
  parameter int LEN_W   = 6,
  parameter int MAX_OUT = 16   // must stay <= 31
) (
  input  logic             clk,
  input  logic             resetbar,
  // request side
  input  logic             start,
  input  logic             req_write,
  input  logic [25:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic [1:0]       req_sz,
  input  logic [2:0]       req_op,
  input  logic [15:0]      wdata,
  input  logic             wdata_valid,
  output logic             wdata_ready,
  output logic [15:0]      rdata,
  output logic             rdata_valid,
  output logic             busy,
  output logic             done,
  output logic             err,
  // controller side
  output logic [2:0]       cmd,
  output logic [25:0]      addr,
  output logic [1:0]       sz,
  output logic [2:0]       op,
  output logic [15:0]      din,
  input  logic             notfull,
  input  logic             ready,
  output logic             read,
  input  logic             validout,
  input  logic [15:0]      dout,
  input  logic [25:0]      raddr
);

  localparam int CNT_W = LEN_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [31:0] MAX_OUT_U = MAX_OUT;

  req_state_t       r_state;
  logic [25:0]      r_addr;
  logic [25:0]      r_exp_addr;
  logic [CNT_W-1:0] r_issue_cnt;
  logic [CNT_W-1:0] r_ret_cnt;
  logic [LEN_W-1:0] r_len;
  logic [1:0]       r_sz;
  logic [2:0]       r_op;
  logic [15:0]      r_rdata;
  logic             r_rdata_valid;
  logic             r_done;
  logic             r_err;
  logic             r_read_d;

  logic [CNT_W-1:0] w_len_ext;
  logic [CNT_W-1:0] w_outst;
  logic             w_outst_ok;
  logic             w_more_to_issue;
  logic             w_wr_ready;
  logic             w_wr_fire;
  logic             w_rd_issue;
  logic             w_read;
  cmd_t             w_cmd;
  logic [15:0]      w_din;

  // Outstanding reads = issued minus returned; counters never wrap within a transfer
  assign w_len_ext       = {1'b0, r_len};
  assign w_outst         = r_issue_cnt - r_ret_cnt;
  assign w_outst_ok      = ({{(32-CNT_W){1'b0}}, w_outst} < MAX_OUT_U);
  assign w_more_to_issue = (r_issue_cnt < w_len_ext);

  // Command issue, write-data handshake and return-FIFO pop decisions.
  // cmd must be NOP whenever notfull is low, so it cannot be registered.
  always_comb begin
    w_wr_ready = 1'b0;
    w_wr_fire  = 1'b0;
    w_rd_issue = 1'b0;
    w_read     = 1'b0;
    w_cmd      = CMD_NOP;
    w_din      = 16'd0;
    case (r_state)
      ST_WR_ISSUE: begin
        w_wr_ready = notfull & ready;
        w_wr_fire  = wdata_valid & notfull & ready;
      end
      ST_RD_RUN: begin
        w_rd_issue = w_more_to_issue & w_outst_ok & ready & notfull;
        // validout lags the FIFO by a cycle: never pop on consecutive cycles
        w_read     = validout & ~r_read_d;
      end
      default: begin
        w_wr_ready = 1'b0;
      end
    endcase
    if (w_wr_fire) begin
      w_cmd = CMD_SCW;
      w_din = wdata;
    end else if (w_rd_issue) begin
      w_cmd = CMD_SCR;
    end else begin
      w_cmd = CMD_NOP;
    end
  end

  // Transfer sequencer: request capture, address/count tracking, return checking
  always_ff @(posedge clk or negedge resetbar) begin
    if (!resetbar) begin
      r_state       <= ST_IDLE;
      r_addr        <= 26'd0;
      r_exp_addr    <= 26'd0;
      r_issue_cnt   <= {CNT_W{1'b0}};
      r_ret_cnt     <= {CNT_W{1'b0}};
      r_len         <= {LEN_W{1'b0}};
      r_sz          <= 2'd0;
      r_op          <= 3'd0;
      r_rdata       <= 16'd0;
      r_rdata_valid <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_read_d      <= 1'b0;
    end else begin
      r_done        <= 1'b0;
      r_rdata_valid <= 1'b0;
      r_read_d      <= w_read;
      case (r_state)
        ST_IDLE: begin
          if (start && ready) begin
            r_addr      <= req_addr;
            r_exp_addr  <= req_addr;
            r_len       <= req_len;
            r_sz        <= req_sz;
            r_op        <= req_op;
            r_err       <= 1'b0;
            r_issue_cnt <= {CNT_W{1'b0}};
            r_ret_cnt   <= {CNT_W{1'b0}};
            if (req_len == {LEN_W{1'b0}}) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else if (req_write) begin
              r_state <= ST_WR_ISSUE;
            end else begin
              r_state <= ST_RD_RUN;
            end
          end
        end
        ST_WR_ISSUE: begin
          if (w_wr_fire) begin
            r_addr      <= addr_next(r_addr);
            r_issue_cnt <= r_issue_cnt + CNT_ONE;
            if (r_issue_cnt + CNT_ONE == w_len_ext) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_RD_RUN: begin
          if (w_rd_issue) begin
            r_addr      <= addr_next(r_addr);
            r_issue_cnt <= r_issue_cnt + CNT_ONE;
          end
          // show-ahead FIFO: dout/raddr are valid in the pop cycle itself
          if (w_read) begin
            r_rdata       <= dout;
            r_rdata_valid <= 1'b1;
            if (raddr != r_exp_addr) begin
              r_err <= 1'b1;
            end
            r_exp_addr <= addr_next(r_exp_addr);
            r_ret_cnt  <= r_ret_cnt + CNT_ONE;
            if (r_ret_cnt + CNT_ONE == w_len_ext) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd         = w_cmd;
  assign din         = w_din;
  assign read        = w_read;
  assign wdata_ready = w_wr_ready;
  assign addr        = r_addr;
  assign sz          = r_sz;
  assign op          = r_op;
  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_valid;
  assign done        = r_done;
  assign err         = r_err;
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ddr3_host_requester.sv
// Scoreboard bench for ddr3_host_requester with a small show-ahead
// controller return-FIFO model.
module tb_ddr3_host_requester;
  import ddr3_pkg::*;

  localparam int LEN_W   = 6;
  localparam int MAX_OUT = 4;
  localparam int LAT     = 3;

  logic             clk = 1'b0;
  logic             resetbar = 1'b1;
  logic             start = 1'b0;
  logic             req_write = 1'b0;
  logic [25:0]      req_addr = 26'd0;
  logic [LEN_W-1:0] req_len = '0;
  logic [1:0]       req_sz = 2'd0;
  logic [2:0]       req_op = 3'd0;
  logic [15:0]      wdata = 16'd0;
  logic             wdata_valid = 1'b0;
  logic             wdata_ready;
  logic [15:0]      rdata;
  logic             rdata_valid, busy, done, err;
  logic [2:0]       cmd;
  logic [25:0]      addr;
  logic [1:0]       sz;
  logic [2:0]       op;
  logic [15:0]      din;
  logic             notfull = 1'b1;
  logic             ready = 1'b1;
  logic             read;
  logic             validout = 1'b0;
  logic [15:0]      dout = 16'd0;
  logic [25:0]      raddr = 26'd0;

  ddr3_host_requester #(.LEN_W(LEN_W), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .resetbar(resetbar), .start(start), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_sz(req_sz), .req_op(req_op),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy), .done(done), .err(err),
    .cmd(cmd), .addr(addr), .sz(sz), .op(op), .din(din),
    .notfull(notfull), .ready(ready), .read(read), .validout(validout),
    .dout(dout), .raddr(raddr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int t_base = 0;

  typedef struct { logic [2:0] c; logic [25:0] a; logic [15:0] d; int cyc; } cmd_exp_t;
  typedef struct { logic [25:0] a; logic [15:0] d; int due; } ret_t;

  cmd_exp_t    exp_cmd[$];
  logic [15:0] exp_rd[$];
  int          exp_done[$];
  logic [1:0]  exp_sz = 2'd0;
  logic [2:0]  exp_op = 3'd0;
  bit          rd_test = 1'b0;

  // monitor-owned counters
  int done_cnt = 0, rv_cnt = 0, iss_cnt = 0, pop_cnt = 0, max_outst = 0;
  bit prev_read = 1'b0;
  cmd_exp_t m_e;

  // controller model state
  ret_t pend[$];
  ret_t fifo[$];
  bit   hold = 1'b0;
  logic [25:0] corrupt_addr = 26'h2AAAAAA;
  logic snap_scr = 1'b0, snap_read = 1'b0;
  logic [25:0] snap_addr = 26'd0;
  bit   m_vo;
  ret_t m_r;

  logic [15:0] wr_words [8] = '{16'hBEEF, 16'h1234, 16'h0F0F, 16'hA001,
                                16'h5A5A, 16'hC3C3, 16'h7E81, 16'h0001};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: compares whatever the DUT presents against the queues
  always @(negedge clk) begin
    if (resetbar) begin
      if (cmd != 3'b000 && notfull) begin
        if (cmd == 3'b001) iss_cnt++;
        if (exp_cmd.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_cmd: got cmd=%0d addr=%0h, required no command", cmd, addr);
        end else begin
          m_e = exp_cmd.pop_front();
          chk("cmd_code", 32'(cmd), 32'(m_e.c));
          chk("cmd_addr", 32'(addr), 32'(m_e.a));
          chk("cmd_sz_op", 32'({sz, op}), 32'({exp_sz, exp_op}));
          if (m_e.c == 3'b010) chk("cmd_din", 32'(din), 32'(m_e.d));
          if (m_e.cyc >= 0) chk("cmd_cycle", 32'(cyc - t_base), 32'(m_e.cyc));
        end
      end
      if (read) begin
        chk("read_spacing", 32'(prev_read), 32'd0);
        pop_cnt++;
      end
      prev_read = read;
      if (iss_cnt - pop_cnt > max_outst) max_outst = iss_cnt - pop_cnt;
      if (rdata_valid) begin
        rv_cnt++;
        if (exp_rd.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_rdata: got %0h, required no word", rdata);
        end else begin
          chk("rdata", 32'(rdata), 32'(exp_rd.pop_front()));
        end
      end
      if (done) begin
        done_cnt++;
        if (exp_done.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_done: got done=1, required 0");
        end else begin
          m_e.cyc = exp_done.pop_front();
          if (m_e.cyc >= 0) chk("done_cycle", 32'(cyc - t_base), 32'(m_e.cyc));
        end
        if (rd_test) chk("done_with_last_rdata", 32'(rdata_valid), 32'd1);
      end
    end else begin
      prev_read = 1'b0;
    end
  end

  // Snapshot controller-side handshakes away from the clock edge
  always @(negedge clk) begin
    snap_scr  = resetbar && (cmd == 3'b001) && notfull;
    snap_read = resetbar && read;
    snap_addr = addr;
  end

  // Controller model: fixed return latency, optional withholding, lagging validout
  always @(posedge clk or negedge resetbar) begin
    if (!resetbar) begin
      pend.delete();
      fifo.delete();
      validout <= 1'b0;
      dout     <= 16'd0;
      raddr    <= 26'd0;
    end else begin
      m_vo = (fifo.size() > 0);
      if (snap_read) begin
        if (fifo.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL fifo_underflow: got pop of empty return FIFO, required none");
        end else begin
          void'(fifo.pop_front());
        end
      end
      if (snap_scr) begin
        m_r.a   = (snap_addr == corrupt_addr) ? (snap_addr ^ 26'h1) : snap_addr;
        m_r.d   = snap_addr[15:0] ^ 16'hA5A5;
        m_r.due = cyc + LAT;
        pend.push_back(m_r);
      end
      while (!hold && pend.size() > 0 && pend[0].due <= cyc) fifo.push_back(pend.pop_front());
      validout <= m_vo;
      dout     <= (fifo.size() > 0) ? fifo[0].d : 16'd0;
      raddr    <= (fifo.size() > 0) ? fifo[0].a : 26'd0;
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_cmd"}, 32'(cmd), 32'd0);
    chk({tag, "_addr"}, 32'(addr), 32'd0);
    chk({tag, "_din"}, 32'(din), 32'd0);
    chk({tag, "_read"}, 32'(read), 32'd0);
    chk({tag, "_wdata_ready"}, 32'(wdata_ready), 32'd0);
    chk({tag, "_rdata"}, 32'({rdata_valid, rdata}), 32'd0);
    chk({tag, "_busy_done_err"}, 32'({busy, done, err}), 32'd0);
  endtask

  task automatic issue_start(input bit wr, input logic [25:0] a, input int n);
    req_write = wr;
    req_addr  = a;
    req_len   = LEN_W'(n);
    req_sz    = wr ? 2'b01 : 2'b10;
    req_op    = wr ? 3'b011 : 3'b110;
    exp_sz    = req_sz;
    exp_op    = req_op;
    start     = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    t_base = cyc - 1;
  endtask

  task automatic wait_done(input int d0, input int budget, input string tag);
    int i = 0;
    while (done_cnt == d0 && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    chk(tag, 32'(done_cnt - d0), 32'd1);
  endtask

  // Write n words; nf_low (1-based cycle, 0 = none) forces notfull low once
  task automatic do_write(input logic [25:0] a, input int n, input int nf_low, input int woff);
    int d0, idx, rel, cyc_k;
    bit fire;
    rd_test = 1'b0;
    for (int k = 0; k < n; k++) begin
      cyc_k = (nf_low != 0 && k + 1 >= nf_low) ? k + 2 : k + 1;
      exp_cmd.push_back('{3'b010, a + 26'(k), wr_words[k + woff], cyc_k});
    end
    exp_done.push_back((nf_low != 0) ? n + 2 : n + 1);
    d0 = done_cnt;
    idx = 0;
    wdata = wr_words[woff];
    wdata_valid = 1'b1;
    notfull = 1'b1;
    issue_start(1'b1, a, n);
    chk("err_clear_on_start", 32'(err), 32'd0);
    rel = 1;
    notfull = (rel != nf_low);
    for (int i = 0; i < 40 && done_cnt == d0; i++) begin
      @(negedge clk);
      if (nf_low != 0 && rel == nf_low) begin
        chk("stall_cmd_nop", 32'(cmd), 32'd0);
        chk("stall_addr_hold", 32'(addr), 32'(a + 26'(nf_low - 1)));
      end
      fire = wdata_ready && wdata_valid;
      @(posedge clk); #1;
      if (fire && idx < n - 1) begin
        idx++;
        wdata = wr_words[idx + woff];
      end else if (fire) begin
        wdata_valid = 1'b0;
      end
      rel = cyc - t_base;
      notfull = (rel != nf_low);
    end
    chk("wr_done_seen", 32'(done_cnt - d0), 32'd1);
    wdata_valid = 1'b0;
    notfull = 1'b1;
  endtask

  task automatic do_read(input logic [25:0] a, input int n, input bit hold_first);
    int d0, rv0, i0;
    logic [25:0] ak;
    for (int k = 0; k < n; k++) begin
      ak = a + 26'(k);
      exp_cmd.push_back('{3'b001, ak, 16'd0, -1});
      exp_rd.push_back(ak[15:0] ^ 16'hA5A5);
    end
    exp_done.push_back(-1);
    d0 = done_cnt; rv0 = rv_cnt; i0 = iss_cnt;
    rd_test = 1'b1;
    hold = hold_first;
    issue_start(1'b0, a, n);
    if (hold_first) begin
      repeat (12) @(posedge clk);
      #1;
      chk("outstanding_cap", 32'(iss_cnt - i0), 32'(MAX_OUT));
      hold = 1'b0;
    end
    wait_done(d0, 400, "rd_done_seen");
    chk("rd_word_count", 32'(rv_cnt - rv0), 32'(n));
    rd_test = 1'b0;
  endtask

  initial begin
    int d0, rv0, i;
    #2 resetbar = 1'b0;
    #10;
    check_idle_outputs("reset");
    @(posedge clk); #1;
    resetbar = 1'b1;
    @(posedge clk); #1;

    // 4-word write, no back-pressure
    do_write(26'h0000100, 4, 0, 0);
    // 3-word write with notfull low in cycle 2
    do_write(26'h0000100, 3, 2, 4);

    // start while ready is low is ignored
    ready = 1'b0;
    req_write = 1'b1; req_addr = 26'h55; req_len = LEN_W'(3); start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    chk("start_ignored_busy", 32'(busy), 32'd0);
    ready = 1'b1;
    @(posedge clk); #1;

    // zero-length request goes straight to done
    exp_done.push_back(1);
    d0 = done_cnt;
    issue_start(1'b1, 26'h0000123, 0);
    wait_done(d0, 10, "len0_done_seen");
    chk("len0_busy_after", 32'(busy), 32'd0);

    // 8-word read across the address wrap
    do_read(26'h3FFFFFE, 8, 1'b0);
    chk("wrap_err", 32'(err), 32'd0);

    // 20-word read with returns withheld until the outstanding cap is hit
    do_read(26'h0001000, 20, 1'b1);
    chk("max_outstanding", 32'(max_outst), 32'(MAX_OUT));

    // corrupted return address on word 2
    corrupt_addr = 26'h0000202;
    do_read(26'h0000200, 5, 1'b0);
    chk("err_set_after_done", 32'(err), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("err_sticky", 32'(err), 32'd1);
    corrupt_addr = 26'h2AAAAAA;
    do_write(26'h0000700, 1, 0, 7);

    // reset asserted mid-read after three returns
    rv0 = rv_cnt;
    for (int k = 0; k < 8; k++) begin
      exp_cmd.push_back('{3'b001, 26'h40 + 26'(k), 16'd0, -1});
      exp_rd.push_back((16'h40 + 16'(k)) ^ 16'hA5A5);
    end
    exp_done.push_back(-1);
    rd_test = 1'b1;
    issue_start(1'b0, 26'h0000040, 8);
    i = 0;
    while (rv_cnt - rv0 < 3 && i < 200) begin
      @(posedge clk); #1;
      i++;
    end
    chk("abort_returns_seen", 32'(rv_cnt - rv0), 32'd3);
    resetbar = 1'b0;
    #1;
    check_idle_outputs("abort");
    exp_cmd.delete(); exp_rd.delete(); exp_done.delete();
    rd_test = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    resetbar = 1'b1;
    @(posedge clk); #1;
    do_write(26'h0000300, 2, 0, 2);
    do_read(26'h0000500, 3, 1'b0);

    @(posedge clk); #1;
    chk("exp_cmd_drained", 32'(exp_cmd.size()), 32'd0);
    chk("exp_rd_drained", 32'(exp_rd.size()), 32'd0);
    chk("exp_done_drained", 32'(exp_done.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ddr3_host_requester.md
# ddr3_host_requester

Host-side initiator for the DDR3 controller's client port. It turns one block-transfer request into a sequence of single-word SCW/SCR commands on the controller's `cmd`/`addr`/`din` interface, respecting `notfull`. For reads it drains the controller's return FIFO through `read`/`validout`, checks each returned address and streams the data out. It sits between a traffic source (test engine or bus bridge) and the DDR3 controller.

## Interface
- `LEN_W`, 6: width of `req_len`; a transfer is 1..2^LEN_W−1 words.
- `MAX_OUT`, 16: maximum outstanding (issued, not yet returned) reads; must be ≤ 31.
- `clk` in 1: single clock.
- `resetbar` in 1: asynchronous, active-low reset.
- `start` in 1: request strobe, sampled in IDLE only.
- `req_write` in 1: 1 = write transfer, 0 = read transfer.
- `req_addr` in 26: first word address.
- `req_len` in LEN_W: word count.
- `req_sz` in 2, `req_op` in 3: captured at start, driven unchanged on every command.
- `wdata` in 16, `wdata_valid` in 1, `wdata_ready` out 1: write data stream.
- `rdata` out 16, `rdata_valid` out 1: read data stream, one-cycle pulse per word.
- `busy` out 1, `done` out 1 (one-cycle pulse), `err` out 1 (sticky return-address mismatch).
- Controller side:
  - `cmd` out 3, `addr` out 26, `sz` out 2, `op` out 3, `din` out 16
  - `notfull` in 1, `ready` in 1
  - `read` out 1, `validout` in 1, `dout` in 16, `raddr` in 26

## Operation
- Command codes: NOP=000, SCR=001, SCW=010. The controller counts an accept in every cycle where `cmd`≠NOP and `notfull`=1. `cmd` is therefore combinationally NOP whenever `notfull`=0.
- States: IDLE, WR_ISSUE, RD_RUN, DONE.
- **IDLE:**
  - With `start`=1 and `ready`=1, capture `req_*`, clear `err`, and go to WR_ISSUE or RD_RUN.
  - With `req_len`=0, go directly to DONE.
  - `start` with `ready`=0, or in any state other than IDLE, is ignored.
- **WR_ISSUE:**
  - `wdata_ready` = `notfull` & `ready`.
  - `cmd`=SCW and `din`=`wdata` when `wdata_valid` & `wdata_ready`.
  - Each accept increments `addr` (mod 2^26) and `issue_cnt`.
  - After `req_len` accepts, go to DONE.
- **RD_RUN, issue side:**
  - `cmd`=SCR when `issue_cnt`<`req_len`, `issue_cnt`−`ret_cnt`<`MAX_OUT`, `ready`=1 and `notfull`=1.
  - `addr` advances on each accept.
- **RD_RUN, return side:**
  - `read`=1 when `validout`=1 and `read` was 0 in the previous cycle. This pops at most every other cycle because `validout` lags the FIFO by one cycle.
  - `dout`/`raddr` are sampled in the `read` cycle (show-ahead FIFO). `rdata` gets `dout` and `rdata_valid`=1 on the next cycle.
  - If `raddr` ≠ `exp_addr`, set `err` (sticky). `exp_addr` and `ret_cnt` then increment.
  - Issue and return proceed concurrently in the same cycle.
  - When `ret_cnt` reaches `req_len`, go to DONE.
- **DONE:** `done`=1 for one cycle, then IDLE.
- `busy` = state≠IDLE.
- `ready` dropping mid-transfer stalls issue only. Draining continues.
- Reset values: `cmd`=000, `read`=0, `wdata_ready`=0, `rdata_valid`=0, `busy`=0, `done`=0, `err`=0, `addr`/`rdata`/`din`=0. State is IDLE and all counters are 0.
- Reset asserted mid-transfer aborts immediately. Outstanding controller entries are not recovered.

## Timing
- With `start` at edge 0, the first command is presented in cycle 1.
- Write of N words with `notfull`=`wdata_valid`=1: commands in cycles 1..N, `done` in cycle N+1.
- Read: latency of the first `rdata_valid` = controller return latency + 2 cycles after `validout` rises. The last `rdata_valid` coincides with `done`.
- Counters are LEN_W+1 bits wide. The outstanding difference never exceeds `MAX_OUT`.

## Structure
- Command codes NOP/SCR/SCW and the state encoding belong in the shared package `ddr3_pkg`, also used by the controller.
- Single module, no sub-modules. The outstanding-read counter is plain logic inside it.

## Test plan
- Write of 4 words at 0x0000100, `notfull`=1: `cmd`=SCW with `addr` 0x100..0x103 and `din` = the input words in cycles 1–4; `done` in cycle 5.
- Write of 3 words with `notfull` low in cycle 2: no accept that cycle and `cmd`=NOP; `addr` holds 0x101; `done` is delayed one cycle.
- Read of 8 words at 0x3FFFFFE against a controller model: addresses wrap 0x3FFFFFE, 0x3FFFFFF, 0x0..0x5; 8 `rdata_valid` pulses; `read` is never high in two consecutive cycles; `err`=0.
- Read of 20 words with `MAX_OUT`=4 and the model withholding returns: issue stops at 4 outstanding and resumes on each pop; 20 words returned in order.
- Model returns a wrong `raddr` on word 2: `err`=1 remains set after `done` and clears on the next accepted `start`.
- `resetbar` low during a read after 3 returns: all outputs take their reset values immediately and the next `start` is accepted normally.
